// File: rtl/md_unit.sv
// rtl/md_unit.sv - EX-stage multi-cycle multiply/divide unit with HI/LO registers.
// Results come from a combinational datapath on latched operands, registered when the countdown expires.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [3:0] OP_MULT  = 4'd3;
   localparam logic [3:0] OP_MULTU = 4'd4;
   localparam logic [3:0] OP_DIV   = 4'd8;
   localparam logic [3:0] OP_DIVU  = 4'd9;
   localparam logic [3:0] OP_MTHI  = 4'd10;
   localparam logic [3:0] OP_MTLO  = 4'd11;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] count;
   logic [3:0]    op_q;
   logic [31:0]   a_q;
   logic [31:0]   b_q;

   logic          accept;
   logic          done;
   logic          op_signed;
   logic          op_is_div;
   logic          a_neg;
   logic          b_neg;
   logic [31:0]   a_mag;
   logic [31:0]   b_mag;
   logic [31:0]   b_div;
   logic [63:0]   prod_mag;
   logic [63:0]   prod;
   logic [31:0]   quo_mag;
   logic [31:0]   rem_mag;
   logic [31:0]   quo;
   logic [31:0]   rem;

   always_comb begin
      accept = (state == IDLE) && start &&
               (md_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
      done   = (state == RUN) && (count == CW'(1));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (done)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
   end

   // Sign-magnitude datapath: signed ops become unsigned ops on magnitudes, which
   // also makes 0x80000000 / -1 yield 0x80000000 with no special case.
   always_comb begin
      op_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
      op_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
      a_neg     = op_signed && a_q[31];
      b_neg     = op_signed && b_q[31];
      a_mag     = a_neg ? -a_q : a_q;
      b_mag     = b_neg ? -b_q : b_q;
      b_div     = (b_mag == 32'd0) ? 32'd1 : b_mag;
      prod_mag  = {32'd0, a_mag} * {32'd0, b_mag};
      prod      = (a_neg ^ b_neg) ? -prod_mag : prod_mag;
      quo_mag   = a_mag / b_div;
      rem_mag   = a_mag % b_div;
      quo       = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
      rem       = a_neg ? -rem_mag : rem_mag;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else if (accept) begin
         a_q   <= rs;
         b_q   <= rt;
         op_q  <= md_op;
         count <= (md_op == OP_DIV || md_op == OP_DIVU) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (state == IDLE && start) begin
         if (md_op == OP_MTHI) hi <= rs;
         if (md_op == OP_MTLO) lo <= rs;
      end else if (state == RUN) begin
         if (done) begin
            count <= '0;
            if (!op_is_div) begin
               hi <= prod[63:32];
               lo <= prod[31:0];
            end else if (b_q != 32'd0) begin
               hi <= rem;
               lo <= quo;
            end
         end else begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - Scoreboard bench for md_unit: directed ops, monitor checks busy length and HI/LO.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  md_op = 4'd0;
   logic [31:0] rs = 32'd0;
   logic [31:0] rt = 32'd0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          cycles;
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      string       name;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
      .rs(rs), .rt(rt), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: measures each busy window and compares against the scoreboard head.
   logic prev_busy = 1'b0;
   int   busy_len = 0;
   logic hold_bad = 1'b0;
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_busy = 1'b0;
         busy_len  = 0;
         hold_bad  = 1'b0;
      end else begin
         if (busy) begin
            busy_len++;
            if (sb.size() > 0 && (hi !== sb[0].old_hi || lo !== sb[0].old_lo)) hold_bad = 1'b1;
         end else if (prev_busy) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_op: busy window of %0d cycles with empty scoreboard", busy_len);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk({e.name, "_cycles"}, busy_len, e.cycles);
               chk({e.name, "_hold"}, {31'd0, hold_bad}, 32'd0);
               chk({e.name, "_hi"}, hi, e.exp_hi);
               chk({e.name, "_lo"}, lo, e.exp_lo);
            end
            busy_len = 0;
            hold_bad = 1'b0;
         end
         prev_busy = busy;
      end
   end

   task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int ncyc);
      exp_t e;
      e.exp_hi = ehi; e.exp_lo = elo; e.cycles = ncyc;
      e.old_hi = m_hi; e.old_lo = m_lo; e.name = name;
      sb.push_back(e);
      m_hi = ehi;
      m_lo = elo;
      start = 1'b1; md_op = op; rs = a; rt = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL timeout: %0d ops still pending", sb.size());
         sb.delete();
      end
   endtask

   task automatic mt(input string name, input logic [3:0] op, input logic [31:0] v);
      start = 1'b1; md_op = op; rs = v; rt = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      if (op == 4'd10) m_hi = v;
      if (op == 4'd11) m_lo = v;
      chk({name, "_hi"}, hi, m_hi);
      chk({name, "_lo"}, lo, m_lo);
      chk({name, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      @(posedge clk); #1;

      issue("mult", 4'd3, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
      wait_done();
      issue("multu", 4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
      wait_done();
      issue("div", 4'd8, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      wait_done();
      issue("divu", 4'd9, 32'd7, 32'd2, 32'd1, 32'd3, 10);
      wait_done();
      issue("divu_zero", 4'd9, 32'd100, 32'd0, 32'd1, 32'd3, 10);
      wait_done();
      issue("div_zero", 4'd8, 32'hFFFF_FF00, 32'd0, 32'd1, 32'd3, 10);
      wait_done();
      issue("div_ovf", 4'd8, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
      wait_done();
      issue("div_mix", 4'd8, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10);
      wait_done();

      mt("mthi", 4'd10, 32'h1234_5678);
      mt("mtlo", 4'd11, 32'hCAFE_F00D);
      mt("noop", 4'd5, 32'hDEAD_BEEF);

      // mtlo arriving mid-mult must be ignored
      issue("mult_coll", 4'd3, 32'd7, 32'd6, 32'd0, 32'd42, 5);
      start = 1'b1; md_op = 4'd11; rs = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      md_op = 4'd8; rt = 32'd1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();

      // back-to-back: second mult presented the cycle busy drops
      issue("b2b_a", 4'd3, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 5);
      for (int i = 0; i < 20 && busy; i++) begin
         @(posedge clk); #1;
      end
      issue("b2b_b", 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 5);
      wait_done();

      issue("div_abort", 4'd8, 32'd1000, 32'd3, 32'd1, 32'd333, 10);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      sb.delete();
      m_hi = 32'd0;
      m_lo = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_abort_busy", {31'd0, busy}, 32'd0);
      chk("post_abort_lo", lo, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
